// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding, default sizing
// and a constant-foldable log2 helper for deriving index widths.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_IDX_W    = 2;
  localparam int DEF_MAX_HOLD = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_prio_encoder.sv
// Rotating-priority encoder: the requester at ptr has highest priority, then
// ptr+1, ... wrapping mod N. Purely combinational.
module rr_prio_encoder
  import arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] first;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[N-1:0];
    win_vld = |rot;
    first   = '0;
    // Scanning downward lets the lowest set bit overwrite, giving LSB priority.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = IDX_W'(i);
    end
    win_idx = first + ptr;
  end

endmodule

// File: rtl/rr_arbiter_4req.sv
// Round-robin arbiter with registered one-hot grant, owner hold tracking and
// hold-limit preemption; at least one idle cycle separates tenures.
module rr_arbiter_4req
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDX_W    = clog2(N),
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             preempt
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [IDX_W-1:0] owner, owner_d;
  logic [7:0]       hold_cnt, hold_cnt_d;

  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             preempt_q, preempt_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_vld;

  rr_prio_encoder #(.N(N), .IDX_W(IDX_W)) u_prio (
    .req     (req),
    .ptr     (ptr),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      hold_cnt  <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      owner     <= owner_d;
      hold_cnt  <= hold_cnt_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    owner_d    = owner;
    hold_cnt_d = hold_cnt;
    unique case (state)
      ST_IDLE: begin
        if (win_vld) begin
          state_d    = ST_GRANT;
          owner_d    = win_idx;
          ptr_d      = win_idx + IDX_W'(1);
          hold_cnt_d = 8'd1;
        end
      end
      ST_GRANT: begin
        // Release is checked first so it wins over a simultaneous timeout.
        if (!req[owner] || hold_cnt == HOLD_LIMIT) begin
          state_d    = ST_IDLE;
          owner_d    = '0;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d     = (state_d == ST_GRANT);
    idx_d     = vld_d ? owner_d : '0;
    grant_d   = '0;
    if (vld_d) grant_d[owner_d] = 1'b1;
    preempt_d = (state == ST_GRANT) && req[owner] && (hold_cnt == HOLD_LIMIT);

    grant     = grant_q;
    grant_idx = idx_q;
    grant_vld = vld_q;
    preempt   = preempt_q;
  end

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// Directed bench for rr_arbiter_4req: reset, single requester, rotation,
// timeout preemption, release-beats-timeout and mid-tenure reset.
module tb_rr_arbiter_4req;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_vld;
  logic       preempt;

  int chk_cnt = 0;
  int err_cnt = 0;

  rr_arbiter_4req dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_grant, input logic [1:0] e_idx,
                           input logic e_vld, input logic e_pre);
    check({tag, ".grant"},   32'(grant),     32'(e_grant));
    check({tag, ".idx"},     32'(grant_idx), 32'(e_idx));
    check({tag, ".vld"},     32'(grant_vld), 32'(e_vld));
    check({tag, ".preempt"}, 32'(preempt),   32'(e_pre));
    check({tag, ".onehot"},  32'($onehot0(grant)), 32'd1);
    check({tag, ".vld_or"},  32'(grant_vld), 32'(|grant));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;

    // Reset with all requests asserted
    tick();
    tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
    check_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester holds for three grant cycles
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_out($sformatf("single.c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    check_out("single.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_out("single.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Rotation from ptr=0, each owner releases after one cycle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [1:0] e;
      logic [3:0] oh;
      e  = 2'(k % 4);
      oh = 4'b0001 << e;
      req = 4'b1111;
      tick();
      check_out($sformatf("rot.g%0d", k), oh, e, 1'b1, 1'b0);
      req = 4'b1111 & ~oh;
      tick();
      check_out($sformatf("rot.i%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Timeout preemption with req=0011 held
    do_reset();
    req = 4'b0011;
    for (int t = 0; t < 2; t++) begin
      logic [1:0] e;
      e = 2'(t);
      for (int c = 1; c <= 8; c++) begin
        tick();
        check_out($sformatf("to.o%0d.c%0d", t, c), 4'b0001 << e, e, 1'b1, 1'b0);
      end
      tick();
      check_out($sformatf("to.pre%0d", t), 4'b0000, 2'd0, 1'b0, 1'b1);
    end
    tick();
    check_out("to.back0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Owner releases on its 8th grant cycle: release wins, no preempt
    for (int c = 2; c <= 8; c++) begin
      tick();
      check_out($sformatf("sim.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0010;
    tick();
    check_out("sim.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_out("sim.next", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_out("sim.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Mid-tenure reset during idx2; ptr=3 beforehand would otherwise pick 3
    req = 4'b1100;
    tick();
    check_out("mrst.g1", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    check_out("mrst.g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_out("mrst.rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_out("mrst.after", 4'b0100, 2'd2, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
